// File: rtl/syzygy_dac_wave_player.sv
// ============================================================================
// syzygy_dac_wave_player -- double-banked DAC waveform player (one-shot/loop)
// Optional macro SYZYGY_DAC_OFFSET_BINARY_EN selects offset-binary output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module syzygy_dac_wave_player #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] play_len,
  input  logic              loop_mode,
  input  logic              start,
  input  logic              stop,
  input  logic              swap_req,
  input  logic              data_en,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              busy,
  output logic              done,
  output logic              active_bank,
  output logic              swap_pend
);

`ifdef SYZYGY_DAC_OFFSET_BINARY_EN
  localparam logic [DATA_W-1:0] IDLE_VAL = {1'b1, {(DATA_W-1){1'b0}}};
`else
  localparam logic [DATA_W-1:0] IDLE_VAL = '0;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] len_q;
  logic              mode_q;

  logic [DATA_W-1:0] mem0 [2**ADDR_W];
  logic [DATA_W-1:0] mem1 [2**ADDR_W];
  logic [DATA_W-1:0] sample;

  function automatic logic [DATA_W-1:0] to_dac(input logic [DATA_W-1:0] s);
`ifdef SYZYGY_DAC_OFFSET_BINARY_EN
    return {~s[DATA_W-1], s[DATA_W-2:0]};
`else
    return s;
`endif
  endfunction

  // Writes go to the bank that is inactive before any same-cycle swap.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (active_bank)
        mem0[wr_addr] <= wr_data;
      else
        mem1[wr_addr] <= wr_data;
    end
  end

  assign sample = active_bank ? mem1[rd_addr] : mem0[rd_addr];
  assign busy   = (state == PLAY);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      rd_addr     <= '0;
      len_q       <= '0;
      mode_q      <= 1'b0;
      active_bank <= 1'b0;
      swap_pend   <= 1'b0;
      valid_o     <= 1'b0;
      done        <= 1'b0;
      data_o      <= IDLE_VAL;
    end else begin
      valid_o <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          data_o <= IDLE_VAL;
          if (swap_req)
            active_bank <= ~active_bank;
          if (start && !stop) begin
            state   <= PLAY;
            rd_addr <= '0;
            len_q   <= play_len;
            mode_q  <= loop_mode;
          end
        end
        PLAY: begin
          if (swap_req)
            swap_pend <= 1'b1;
          if (stop) begin
            state   <= IDLE;
            rd_addr <= '0;
            data_o  <= IDLE_VAL;
          end else if (data_en) begin
            data_o  <= to_dac(sample);
            valid_o <= 1'b1;
            if (rd_addr != len_q) begin
              rd_addr <= rd_addr + ADDR_W'(1);
            end else begin
              rd_addr <= '0;
              // A request arriving on this wrap only sets the flag; it is applied next wrap.
              if (swap_pend) begin
                active_bank <= ~active_bank;
                swap_pend   <= 1'b0;
                len_q       <= play_len;
              end
              if (!mode_q) begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_syzygy_dac_wave_player.sv
// Self-checking bench for syzygy_dac_wave_player: control table plus sample scoreboard.
`default_nettype none

module tb_syzygy_dac_wave_player;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [11:0] wr_data;
  logic [7:0]  play_len;
  logic        loop_mode;
  logic        start;
  logic        stop;
  logic        swap_req;
  logic        data_en;
  logic [11:0] data_o;
  logic        valid_o;
  logic        busy;
  logic        done;
  logic        active_bank;
  logic        swap_pend;

  int checks   = 0;
  int failures = 0;

  logic [11:0] sb [$];
  logic [11:0] m0 [256];
  logic [11:0] m1 [256];

  syzygy_dac_wave_player #(.DATA_W(12), .ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .play_len(play_len), .loop_mode(loop_mode),
    .start(start), .stop(stop), .swap_req(swap_req), .data_en(data_en),
    .data_o(data_o), .valid_o(valid_o), .busy(busy), .done(done),
    .active_bank(active_bank), .swap_pend(swap_pend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef SYZYGY_DAC_OFFSET_BINARY_EN
  localparam logic [11:0] IDLE_VAL = 12'h800;
`else
  localparam logic [11:0] IDLE_VAL = 12'h000;
`endif

  function automatic logic [11:0] fmt(input logic [11:0] s);
`ifdef SYZYGY_DAC_OFFSET_BINARY_EN
    return {~s[11], s[10:0]};
`else
    return s;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [11:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Scoreboard: every valid_o pops the oldest expected sample.
  always @(negedge clk) begin
    if (valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=%0h required=no sample", data_o);
      end else begin
        chk("sample", {20'h0, data_o}, {20'h0, sb.pop_front()});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       start;
    logic       stop;
    logic       den;
    logic [11:0] smp;
    logic       busy;
    logic       valid;
    logic       done;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1, 0, 0, 12'h000, 1, 0, 0};
    tbl[1]  = '{0, 0, 1, 12'h000, 1, 1, 0};
    tbl[2]  = '{0, 0, 0, 12'h000, 1, 0, 0};
    tbl[3]  = '{1, 0, 0, 12'h000, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 12'h000, 1, 0, 0};
    tbl[5]  = '{0, 0, 1, 12'h001, 1, 1, 0};
    tbl[6]  = '{0, 0, 0, 12'h000, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 12'h000, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 12'h000, 1, 0, 0};
    tbl[9]  = '{0, 0, 1, 12'h002, 0, 1, 1};
    tbl[10] = '{0, 0, 1, 12'h000, 0, 0, 0};

    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; play_len = '0;
    loop_mode = 1'b0; start = 1'b0; stop = 1'b0; swap_req = 1'b0; data_en = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    chk("rst_data", {20'h0, data_o}, {20'h0, IDLE_VAL});
    chk("rst_busy", busy, 0);
    chk("rst_bank", active_bank, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_done", done, 0);
    chk("rst_pend", swap_pend, 0);

    // Loop playback from bank1 after an idle swap
    for (int i = 0; i < 4; i++) begin
      m1[i] = 12'(i);
      wr(8'(i), m1[i]);
    end
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    chk("idle_swap_bank", active_bank, 1);
    chk("idle_swap_pend", swap_pend, 0);
    play_len = 8'd3; loop_mode = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_valid", valid_o, 0);
    for (int i = 0; i < 9; i++) begin
      data_en = 1'b1;
      sb.push_back(fmt(m1[i % 4]));
      tick();
      chk("loop_valid", valid_o, 1);
    end
    data_en = 1'b0; tick();
    chk("loop_noden_valid", valid_o, 0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_data", {20'h0, data_o}, {20'h0, IDLE_VAL});

    // One-shot, data_en every 4th cycle, start mid-play ignored
    play_len = 8'd2; loop_mode = 1'b0;
    for (int r = 0; r < 11; r++) begin
      start = tbl[r].start; stop = tbl[r].stop; data_en = tbl[r].den;
      if (tbl[r].valid) sb.push_back(fmt(tbl[r].smp));
      tick();
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].busy);
      chk($sformatf("tbl%0d_valid", r), valid_o, tbl[r].valid);
      chk($sformatf("tbl%0d_done", r), done, tbl[r].done);
    end
    start = 1'b0; stop = 1'b0; data_en = 1'b0;
    chk("oneshot_idle_data", {20'h0, data_o}, {20'h0, IDLE_VAL});

    // Fill bank0; the last write shares a cycle with a swap and must still land in bank0
    for (int i = 0; i < 3; i++) begin
      m0[i] = 12'h010 + 12'(i);
      wr(8'(i), m0[i]);
    end
    m0[3] = 12'h013;
    wr_en = 1'b1; wr_addr = 8'd3; wr_data = m0[3]; swap_req = 1'b1;
    tick();
    wr_en = 1'b0; swap_req = 1'b0;
    chk("swap_wr_bank", active_bank, 0);
    for (int i = 0; i < 4; i++) wr(8'(i), 12'h7FF);

    // Swap during playback, including a request on the wrap cycle itself
    play_len = 8'd3; loop_mode = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    for (int c = 0; c < 13; c++) begin
      swap_req = (c == 1 || c == 7);
      data_en = 1'b1;
      sb.push_back(fmt((c < 4) ? m0[c] : ((c < 12) ? 12'h7FF : m0[0])));
      tick();
      chk($sformatf("swp%0d_bank", c), active_bank, (c >= 3 && c < 11));
      chk($sformatf("swp%0d_pend", c), swap_pend, ((c >= 1 && c < 3) || (c >= 7 && c < 11)));
    end
    swap_req = 1'b0; data_en = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;

    // stop+start together in PLAY keeps a pending swap; reset aborts mid-play
    start = 1'b1; tick(); start = 1'b0;
    data_en = 1'b1; sb.push_back(fmt(m0[0])); tick(); data_en = 1'b0;
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    chk("pre_stop_pend", swap_pend, 1);
    stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_done", done, 0);
    chk("ss_valid", valid_o, 0);
    chk("ss_data", {20'h0, data_o}, {20'h0, IDLE_VAL});
    chk("ss_pend", swap_pend, 1);
    chk("ss_bank", active_bank, 0);
    loop_mode = 1'b0; start = 1'b1; tick(); start = 1'b0;
    chk("restart_busy", busy, 1);
    data_en = 1'b1; sb.push_back(fmt(m0[0])); tick();
    reset_n = 1'b0; tick();
    reset_n = 1'b1; data_en = 1'b0;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_valid", valid_o, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_data", {20'h0, data_o}, {20'h0, IDLE_VAL});
    chk("rstmid_bank", active_bank, 0);
    chk("rstmid_pend", swap_pend, 0);

    // Full-bank loop with wrap; addr 7 holds the 0x800 code
    for (int i = 0; i < 256; i++) begin
      m1[i] = (i == 7) ? 12'h800 : (12'(i) ^ 12'h5A5);
      wr(8'(i), m1[i]);
    end
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    play_len = 8'd255; loop_mode = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 258; i++) begin
      data_en = 1'b1;
      sb.push_back(fmt(m1[i % 256]));
      tick();
    end
    data_en = 1'b0;
    chk("full_still_busy", busy, 1);
    stop = 1'b1; tick(); stop = 1'b0;

    // play_len = 0: one sample per pass, looping then one-shot
    play_len = 8'd0; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_en = 1'b1; sb.push_back(fmt(m1[0])); tick();
      chk("len0_loop_busy", busy, 1);
    end
    data_en = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    loop_mode = 1'b0; start = 1'b1; tick(); start = 1'b0;
    data_en = 1'b1; sb.push_back(fmt(m1[0])); tick(); data_en = 1'b0;
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    tick();
    chk("len0_done_clear", done, 0);
    chk("len0_idle_data", {20'h0, data_o}, {20'h0, IDLE_VAL});

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
